// File: rtl/i2c_reg_responder_pkg.sv
// Shared encodings for the I2C register responder: FSM states and bus-level bit constants.
package i2c_reg_responder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_PTR,
        ST_ACK_PTR,
        ST_WDATA,
        ST_ACK_WDATA,
        ST_RDATA,
        ST_RACK
    } state_t;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus stable-count glitch filter for one I2C line.
// level_o only follows the pad after FILTER_LEN consecutive differing samples; rise_o/fall_o pulse with it.
module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN) + 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync_q[1];
                rise_q  <= sync_q[1];
                fall_q  <= ~sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_reg_responder.sv
// I2C target exposing a DEPTH-entry byte register file behind an auto-incrementing pointer.
// Write: addr+W, pointer, data...; read: addr+R (optionally after a pointer write and repeated START).
module i2c_reg_responder
    import i2c_reg_responder_pkg::*;
#(
    parameter logic [6:0] ADDR       = 7'h50,
    parameter int         DEPTH      = 16,
    parameter int         FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_t,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       addressed
);

    localparam int PW = $clog2(DEPTH);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_i  (clk),
        .rst_i  (rst),
        .line_i (scl_i),
        .level_o(scl_f),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_i  (clk),
        .rst_i  (rst),
        .line_i (sda_i),
        .level_o(sda_f),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    state_t        state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shreg_q;
    logic [PW-1:0] ptr_q;
    logic          rw_q;
    logic          got_ack_q;
    logic          sda_t_q;
    logic          busy_q;
    logic          addressed_q;
    logic          wr_valid_q;
    logic [7:0]    wr_addr_q;
    logic [7:0]    wr_data_q;
    logic [7:0]    regs_q [DEPTH];

    logic [7:0] byte_in;
    logic [7:0] rd_data;

    assign byte_in = {shreg_q[6:0], sda_f};
    assign rd_data = regs_q[ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            got_ack_q   <= 1'b0;
            sda_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            wr_valid_q <= 1'b0;
            // START/STOP outrank any bit activity in the same cycle
            if (scl_f && sda_fall) begin
                state_q     <= ST_ADDR;
                bitcnt_q    <= '0;
                sda_t_q     <= 1'b1;
                busy_q      <= 1'b1;
                addressed_q <= 1'b0;
                got_ack_q   <= 1'b0;
            end else if (scl_f && sda_rise) begin
                state_q     <= ST_IDLE;
                sda_t_q     <= 1'b1;
                busy_q      <= 1'b0;
                addressed_q <= 1'b0;
                got_ack_q   <= 1'b0;
            end else if (scl_rise) begin
                case (state_q)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        shreg_q  <= byte_in;
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) begin
                            case (state_q)
                                ST_ADDR: begin
                                    if (byte_in[7:1] == ADDR) begin
                                        state_q <= ST_ACK_ADDR;
                                        rw_q    <= byte_in[0];
                                    end else begin
                                        state_q <= ST_IDLE;
                                    end
                                end
                                ST_PTR: begin
                                    ptr_q   <= byte_in[PW-1:0];
                                    state_q <= ST_ACK_PTR;
                                end
                                default: begin
                                    regs_q[ptr_q] <= byte_in;
                                    wr_valid_q    <= 1'b1;
                                    wr_addr_q     <= 8'(ptr_q);
                                    wr_data_q     <= byte_in;
                                    ptr_q         <= ptr_q + 1'b1;
                                    state_q       <= ST_ACK_WDATA;
                                end
                            endcase
                        end
                    end
                    ST_RDATA: begin
                        shreg_q  <= {shreg_q[6:0], 1'b0};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) state_q <= ST_RACK;
                    end
                    ST_RACK: begin
                        if (sda_f == I2C_ACK) begin
                            got_ack_q <= 1'b1;
                            ptr_q     <= ptr_q + 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    // first falling edge drives the ACK, the second ends it
                    ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_WDATA: begin
                        if (sda_t_q) begin
                            sda_t_q <= I2C_ACK;
                            if (state_q == ST_ACK_ADDR) addressed_q <= 1'b1;
                        end else begin
                            bitcnt_q <= '0;
                            if (state_q == ST_ACK_ADDR && rw_q == I2C_RW_READ) begin
                                state_q <= ST_RDATA;
                                shreg_q <= rd_data;
                                sda_t_q <= rd_data[7];
                            end else begin
                                state_q <= (state_q == ST_ACK_ADDR) ? ST_PTR : ST_WDATA;
                                sda_t_q <= 1'b1;
                            end
                        end
                    end
                    ST_RDATA: sda_t_q <= shreg_q[7];
                    ST_RACK: begin
                        if (got_ack_q) begin
                            got_ack_q <= 1'b0;
                            state_q   <= ST_RDATA;
                            bitcnt_q  <= '0;
                            shreg_q   <= rd_data;
                            sda_t_q   <= rd_data[7];
                        end else begin
                            sda_t_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign scl_o     = 1'b1;
    assign scl_t     = 1'b1;
    assign sda_o     = sda_t_q;
    assign sda_t     = sda_t_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign addressed = addressed_q;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Directed bench for i2c_reg_responder: bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_reg_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_o, scl_t, sda_o, sda_t;
    logic       wr_valid, busy, addressed;
    logic [7:0] wr_addr, wr_data;
    logic       sda_line;

    assign sda_line = sda_m & sda_t;

    always #5 clk = ~clk;

    i2c_reg_responder #(.ADDR(7'h50), .DEPTH(16), .FILTER_LEN(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .scl_o    (scl_o),
        .scl_t    (scl_t),
        .sda_i    (sda_line),
        .sda_o    (sda_o),
        .sda_t    (sda_t),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .addressed(addressed)
    );

    int         errors = 0;
    int         checks = 0;
    int         wv_cnt = 0;
    logic [7:0] wv_addr[$];
    logic [7:0] wv_data[$];
    logic       mon_en = 1'b0;
    logic       low_seen = 1'b0;

    always @(negedge clk) begin
        if (wr_valid) begin
            wv_cnt++;
            wv_addr.push_back(wr_addr);
            wv_data.push_back(wr_data);
        end
        if (mon_en && !sda_t) low_seen = 1'b1;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: observed no finish, expected finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wv(input int i);
        if (i < wv_addr.size()) return {wv_addr[i], wv_data[i]};
        return 16'hxxxx;
    endfunction

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each bit leaves SCL low and 10 clk into the low phase
    task automatic i2c_start();
        sda_m = 1'b1; w(10);
        scl_m = 1'b1; w(20);
        sda_m = 1'b0; w(20);
        scl_m = 1'b0; w(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; w(10);
        scl_m = 1'b1; w(20);
        sda_m = 1'b1; w(20);
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        sda_m = b; w(10);
        scl_m = 1'b1;
        if (glitch) begin
            w(8); scl_m = 1'b0; w(1); scl_m = 1'b1; w(11);
        end else begin
            w(20);
        end
        scl_m = 1'b0; w(10);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; w(10);
        scl_m = 1'b1; w(10);
        b = sda_line; w(10);
        scl_m = 1'b0; w(10);
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(ack, 1'b0);
    endtask

    logic       a;
    logic [7:0] rd;

    initial begin
        // reset values
        w(5);
        chk("rst_sda_t", sda_t, 1'b1);
        chk("rst_sda_o", sda_o, 1'b1);
        chk("rst_scl_o", scl_o, 1'b1);
        chk("rst_scl_t", scl_t, 1'b1);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addressed", addressed, 1'b0);
        rst = 1'b0;
        w(10);

        // write 0x11,0x22 starting at register 3
        i2c_start();
        chk("wr_busy", busy, 1'b1);
        write_byte(8'hA0, -1, a); chk("wr_ack_addr", a, 1'b0);
        chk("wr_addressed", addressed, 1'b1);
        write_byte(8'h03, -1, a); chk("wr_ack_ptr", a, 1'b0);
        write_byte(8'h11, -1, a); chk("wr_ack_d0", a, 1'b0);
        write_byte(8'h22, -1, a); chk("wr_ack_d1", a, 1'b0);
        i2c_stop();
        chk("wr_busy_stop", busy, 1'b0);
        chk("wr_addressed_stop", addressed, 1'b0);
        chk("wr_count", wv_cnt, 2);
        chk("wr_ev0", wv(0), 16'h0311);
        chk("wr_ev1", wv(1), 16'h0422);

        // pointer write, repeated START, read two bytes
        i2c_start();
        write_byte(8'hA0, -1, a); chk("rd_ack_addr_w", a, 1'b0);
        write_byte(8'h03, -1, a); chk("rd_ack_ptr", a, 1'b0);
        i2c_start();
        write_byte(8'hA1, -1, a); chk("rd_ack_addr_r", a, 1'b0);
        read_byte(rd, 1'b0); chk("rd_byte0", rd, 8'h11);
        read_byte(rd, 1'b1); chk("rd_byte1", rd, 8'h22);
        chk("rd_sda_released", sda_t, 1'b1);
        i2c_stop();
        chk("rd_no_write", wv_cnt, 2);

        // wrong address: bus never driven, nothing written
        mon_en = 1'b1;
        i2c_start();
        write_byte(8'hA2, -1, a); chk("nm_nack_addr", a, 1'b1);
        write_byte(8'h00, -1, a); chk("nm_nack_d0", a, 1'b1);
        write_byte(8'h55, -1, a); chk("nm_nack_d1", a, 1'b1);
        chk("nm_addressed", addressed, 1'b0);
        i2c_stop();
        mon_en = 1'b0;
        chk("nm_sda_low_seen", low_seen, 1'b0);
        chk("nm_no_write", wv_cnt, 2);

        // pointer wrap at DEPTH-1
        i2c_start();
        write_byte(8'hA0, -1, a);
        write_byte(8'h0F, -1, a);
        write_byte(8'hAA, -1, a);
        write_byte(8'hBB, -1, a); chk("wrap_ack", a, 1'b0);
        i2c_stop();
        chk("wrap_ev0", wv(2), 16'h0FAA);
        chk("wrap_ev1", wv(3), 16'h00BB);
        i2c_start();
        write_byte(8'hA0, -1, a);
        write_byte(8'h0F, -1, a);
        i2c_start();
        write_byte(8'hA1, -1, a);
        read_byte(rd, 1'b0); chk("wrap_rd0", rd, 8'hAA);
        read_byte(rd, 1'b1); chk("wrap_rd1", rd, 8'hBB);
        i2c_stop();

        // STOP after 5 data bits discards the partial byte
        i2c_start();
        write_byte(8'hA0, -1, a);
        write_byte(8'h05, -1, a);
        for (int i = 7; i >= 3; i--) write_bit(rd[i] ^ 1'b1 ^ rd[i], 1'b0);
        i2c_stop();
        chk("abort_busy", busy, 1'b0);
        chk("abort_addressed", addressed, 1'b0);
        chk("abort_no_write", wv_cnt, 4);
        i2c_start();
        write_byte(8'hA0, -1, a); chk("abort_next_ack", a, 1'b0);
        write_byte(8'h05, -1, a);
        write_byte(8'h33, -1, a);
        i2c_stop();
        chk("abort_next_ev", wv(4), 16'h0533);

        // 1-clk SCL low glitch during a data bit is filtered out
        i2c_start();
        write_byte(8'hA0, -1, a);
        write_byte(8'h06, -1, a);
        write_byte(8'h5A, 2, a); chk("glitch_ack", a, 1'b0);
        i2c_stop();
        chk("glitch_count", wv_cnt, 6);
        chk("glitch_ev", wv(5), 16'h065A);

        // reset while the target drives a 0 bit of 0x11
        i2c_start();
        write_byte(8'hA0, -1, a);
        write_byte(8'h03, -1, a);
        i2c_start();
        write_byte(8'hA1, -1, a);
        read_bit(a); chk("mr_bit7", a, 1'b0);
        chk("mr_driving", sda_t, 1'b0);
        rst = 1'b1;
        w(1);
        chk("mr_sda_released", sda_t, 1'b1);
        chk("mr_busy", busy, 1'b0);
        rst = 1'b0;
        scl_m = 1'b1;
        w(20);
        i2c_start();
        write_byte(8'hA0, -1, a);
        write_byte(8'h03, -1, a);
        i2c_start();
        write_byte(8'hA1, -1, a); chk("mr_ack_after", a, 1'b0);
        read_byte(rd, 1'b1); chk("mr_regs_cleared", rd, 8'h00);
        i2c_stop();
        chk("mr_no_write", wv_cnt, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
